// File: rtl/shift_sweep_pkg.sv
// Shared types and constants for the shift sweep sequencer.
// Ports: none (package only).
package shift_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } sweep_state_t;

    localparam logic LR_RIGHT = 1'b1;
    localparam logic LR_LEFT  = 1'b0;

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-M prescaler producing a one-cycle tick every M enabled cycles.
// Ports: clk, reset (async, high), clr (sync clear), en (count enable),
//        tick (high while count == M-1 and enabled).
module mod_m_counter #(
    parameter int M = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Gated by en so a phase frozen at M-1 during PAUSE never leaks out.
    assign tick = en && (count == LAST);

endmodule

// File: rtl/shift_sweep_ctrl.sv
// Sequencer stepping a barrel shifter's amount through 0..W-1 per tick.
// Ports: clk, reset (async, high); load/din/dir_in operand capture;
//        start/stop/step/cont/auto_rev control; a/amt/lr to the shifter;
//        busy (RUN or PAUSE), done (single-sweep completion pulse).
module shift_sweep_ctrl
    import shift_sweep_pkg::*;
#(
    parameter int W      = 16,
    parameter int AW     = $clog2(W),
    parameter int TICK_M = 5_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  din,
    input  logic          dir_in,
    input  logic          start,
    input  logic          stop,
    input  logic          step,
    input  logic          cont,
    input  logic          auto_rev,
    output logic [W-1:0]  a,
    output logic [AW-1:0] amt,
    output logic          lr,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] AMT_MAX = AW'(W - 1);

    sweep_state_t  state, state_n;
    logic [W-1:0]  a_n;
    logic [AW-1:0] amt_n;
    logic          lr_n;
    logic          done_n;
    logic          adv;
    logic          go;
    logic          tick;

    // go marks start acceptance; it realigns the prescaler phase.
    mod_m_counter #(
        .M(TICK_M)
    ) u_presc (
        .clk  (clk),
        .reset(reset),
        .clr  (go),
        .en   (state == RUN),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        a_n     = a;
        amt_n   = amt;
        lr_n    = lr;
        done_n  = 1'b0;
        adv     = 1'b0;
        go      = 1'b0;

        unique case (state)
            IDLE: begin
                amt_n = '0;
                if (load) begin
                    a_n  = din;
                    lr_n = dir_in;
                end
                if (start) begin
                    state_n = RUN;
                    go      = 1'b1;
                end
            end
            RUN: begin
                // stop discards a coincident tick
                if (stop) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    adv = 1'b1;
                end
            end
            PAUSE: begin
                if (load) begin
                    a_n  = din;
                    lr_n = dir_in;
                end
                if (stop) begin
                    state_n = PAUSE;
                end else if (start) begin
                    state_n = RUN;
                    go      = 1'b1;
                end else if (step) begin
                    adv = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (adv) begin
            if (amt != AMT_MAX) begin
                amt_n = amt + 1'b1;
            end else begin
                amt_n = '0;
                if (cont) begin
                    if (auto_rev) begin
                        lr_n = (lr == LR_RIGHT) ? LR_LEFT : LR_RIGHT;
                    end
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            amt   <= '0;
            lr    <= LR_RIGHT;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            amt   <= amt_n;
            lr    <= lr_n;
            done  <= done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Self-checking bench for shift_sweep_ctrl (W=16, TICK_M=4).
// Ports: none (top-level bench).
module tb_shift_sweep_ctrl;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int TM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [W-1:0]  din;
    logic          dir_in;
    logic          start;
    logic          stop;
    logic          step;
    logic          cont;
    logic          auto_rev;
    logic [W-1:0]  a;
    logic [AW-1:0] amt;
    logic          lr;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [22:0] exp_q[$];

    int           m_st;
    int           m_cnt;
    logic [W-1:0] m_a;
    int           m_amt;
    logic         m_lr;
    logic         m_done;

    bit done_seen;

    shift_sweep_ctrl #(
        .W(W),
        .AW(AW),
        .TICK_M(TM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .dir_in  (dir_in),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .cont    (cont),
        .auto_rev(auto_rev),
        .a       (a),
        .amt     (amt),
        .lr      (lr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_cnt  = 0;
        m_a    = '0;
        m_amt  = 0;
        m_lr   = 1'b1;
        m_done = 1'b0;
        exp_q.delete();
    endtask

    // Reference behaviour for one clock edge, given current inputs.
    task automatic model_step();
        int   st0  = m_st;
        int   cnt0 = m_cnt;
        bit   acc  = 0;
        bit   adv  = 0;
        m_done = 1'b0;
        if (st0 == 0) begin
            if (load) begin
                m_a  = din;
                m_lr = dir_in;
            end
            if (start) begin
                m_st = 1;
                acc  = 1;
            end
        end else if (st0 == 1) begin
            if (stop) m_st = 2;
            else if (cnt0 == TM - 1) adv = 1;
        end else begin
            if (load) begin
                m_a  = din;
                m_lr = dir_in;
            end
            if (!stop) begin
                if (start) begin
                    m_st = 1;
                    acc  = 1;
                end else if (step) begin
                    adv = 1;
                end
            end
        end
        if (acc) m_cnt = 0;
        else if (st0 == 1) m_cnt = (cnt0 + 1) % TM;
        if (adv) begin
            if (m_amt < W - 1) begin
                m_amt = m_amt + 1;
            end else begin
                m_amt = 0;
                if (cont) begin
                    if (auto_rev) m_lr = ~m_lr;
                end else begin
                    m_done = 1'b1;
                    m_st   = 0;
                end
            end
        end
        exp_q.push_back({m_a, 4'(m_amt), m_lr, (m_st != 0), m_done});
    endtask

    task automatic cyc();
        logic [22:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("outs", {9'd0, a, amt, lr, busy, done}, {9'd0, e});
        end
        if (done) done_seen = 1;
    endtask

    initial begin
        reset = 1'b1; load = 0; din = '0; dir_in = 0;
        start = 0; stop = 0; step = 0; cont = 0; auto_rev = 0;
        done_seen = 0;
        model_reset();
        #12;
        chk("rst_a", a, 0);
        chk("rst_amt", amt, 0);
        chk("rst_lr", lr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // load in IDLE
        load = 1; din = 16'h2465; dir_in = 0;
        cyc();
        load = 0;
        chk("ld_a", a, 16'h2465);
        chk("ld_lr", lr, 0);
        for (int i = 0; i < 3; i++) cyc();
        chk("idle_amt", amt, 0);
        chk("idle_busy", busy, 0);

        // single sweep
        cont = 0;
        start = 1;
        cyc();
        start = 0;
        chk("ss_busy0", busy, 1);
        for (int k = 1; k <= 64; k++) begin
            cyc();
            if (k == 3) chk("ss_amt3", amt, 0);
            if (k % 4 == 0 && k < 64) chk("ss_amt", amt, 32'(k / 4));
            if (k == 63) chk("ss_busy63", busy, 1);
            if (k == 63) chk("ss_done63", done, 0);
        end
        chk("ss_amt64", amt, 0);
        chk("ss_done64", done, 1);
        chk("ss_busy64", busy, 0);
        cyc();
        chk("ss_done65", done, 0);

        // continuous with auto reverse
        load = 1; dir_in = 1;
        cyc();
        load = 0;
        cont = 1; auto_rev = 1; done_seen = 0;
        start = 1;
        cyc();
        start = 0;
        for (int k = 1; k <= 128; k++) begin
            cyc();
            if (k == 63) chk("cr_lr63", lr, 1);
            if (k == 64) chk("cr_lr64", lr, 0);
            if (k == 127) chk("cr_lr127", lr, 0);
            if (k == 128) chk("cr_lr128", lr, 1);
        end
        chk("cr_nodone", {31'd0, done_seen}, 0);
        stop = 1;
        cyc();
        stop = 0;
        cont = 0; auto_rev = 0;

        // pause, step, load, resume
        start = 1;
        cyc();
        start = 0;
        for (int k = 1; k <= 20; k++) cyc();
        chk("p_amt5", amt, 5);
        stop = 1;
        cyc();
        stop = 0;
        chk("p_hold5", amt, 5);
        chk("p_busy", busy, 1);
        step = 1;
        for (int i = 0; i < 3; i++) cyc();
        step = 0;
        chk("p_step8", amt, 8);
        load = 1; din = 16'h0001; dir_in = 1;
        cyc();
        load = 0;
        chk("p_ld_a", a, 16'h0001);
        chk("p_ld_amt", amt, 8);
        start = 1;
        cyc();
        start = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 3) chk("p_res3", amt, 8);
            if (k == 4) chk("p_res4", amt, 9);
        end

        // stop coincident with tick; start+stop in PAUSE
        stop = 1;
        cyc();
        stop = 0;
        cont = 1; auto_rev = 0;
        step = 1;
        for (int i = 0; i < 13; i++) cyc();
        step = 0;
        chk("t_amt6", amt, 6);
        chk("t_lr", lr, 1);
        start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 3; i++) cyc();
        stop = 1;
        cyc();
        stop = 0;
        chk("t_tickstop", amt, 6);
        chk("t_busy", busy, 1);
        start = 1; stop = 1;
        cyc();
        start = 0; stop = 0;
        for (int i = 0; i < 8; i++) cyc();
        chk("t_ss_hold", amt, 6);

        // step+start in PAUSE, then async reset mid-run
        step = 1; start = 1;
        cyc();
        start = 0;
        chk("r_nostep", amt, 6);
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) step = 0;
            cyc();
        end
        chk("r_amt11", amt, 11);
        cyc();
        cyc();
        #1;
        reset = 1;
        #1;
        chk("ar_a", a, 0);
        chk("ar_amt", amt, 0);
        chk("ar_lr", lr, 1);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        model_reset();
        #1;
        reset = 0;
        start = 1;
        cyc();
        start = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 3) chk("ar_res3", amt, 0);
            if (k == 4) chk("ar_res4", amt, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sweep_ctrl.md
# shift_sweep_ctrl

Sequencer that drives the operand, shift amount and direction inputs of the reversible barrel shifter (`barrel_shifter_rev_16`/`_32`). It sits directly upstream of the shifter, and its `a`/`amt`/`lr` outputs connect straight to the shifter's ports. It holds a loaded operand and steps `amt` through 0..W-1 at a prescaled tick rate, producing a visible rotating/shifting pattern on the board. It supports single or continuous sweeps, pause, single-step and automatic direction reversal.

## Interface
- `W`, 16: operand width; 16 or 32 only.
- `AW`, $clog2(W): amount width (4 or 5).
- `TICK_M`, 5_000_000: clock cycles per advance tick; minimum 2.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: **asynchronous, active-high** reset.
- `load` input 1: capture `din` and `dir_in`; honoured only in IDLE or PAUSE.
- `din` input W: operand to load.
- `dir_in` input 1: direction to load; 1 = right, 0 = left.
- `start` input 1: IDLE→RUN, or PAUSE→RUN (resume).
- `stop` input 1: RUN→PAUSE.
- `step` input 1: in PAUSE, advance `amt` once.
- `cont` input 1: 1 = continuous sweep, 0 = single sweep.
- `auto_rev` input 1: in continuous mode, toggle `lr` on each wrap.
- `a` output W: operand to shifter (registered).
- `amt` output AW: shift amount to shifter (registered).
- `lr` output 1: direction to shifter; 1 = right (registered).
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: one-cycle pulse at single-sweep completion.

## Operation
- Reset values: `a`=0, `amt`=0, `lr`=1, `busy`=0, `done`=0, state IDLE, prescaler=0.
- States:
  - IDLE: `amt` held at 0. `start` → RUN, with the prescaler cleared.
  - RUN: on each tick, perform an advance (see below). `stop` → PAUSE.
  - PAUSE: everything held. `step` performs one advance. `start` → RUN, with the prescaler cleared.
- Advance:
  - If `amt`<W-1: `amt`+1.
  - If `amt`=W-1 and `cont`=1: `amt`→0; `lr` toggles iff `auto_rev`=1; stay in the current state.
  - If `amt`=W-1 and `cont`=0: `amt`→0, `done`=1 for one cycle, →IDLE.
- Arithmetic: `amt` wraps modulo W, never exceeds W-1. `cont` and `auto_rev` are sampled at the wrap cycle, not latched at start.
- `load` in IDLE/PAUSE: `a`←`din`, `lr`←`dir_in`, `amt` unchanged. `load` in RUN is ignored.
- Simultaneous events:
  - `reset` overrides everything.
  - `stop` and `start` in the same cycle: `stop` wins (RUN→PAUSE; PAUSE stays).
  - `load` with `start` in IDLE/PAUSE: both take effect in the same edge.
  - `step` with `start` in PAUSE: `start` wins; no extra advance.
  - Tick coinciding with `stop` in RUN: the advance is discarded; the state goes to PAUSE.
  - `stop` in IDLE and `step` in RUN/IDLE are ignored.
- Reset mid-sweep: all outputs return to reset values asynchronously. The prescaler phase is lost.

## Timing
- All outputs are registered. Each change appears one clock after the qualifying input or tick edge.
- The prescaler counts 0..TICK_M-1 only in RUN. Tick = (count == TICK_M-1), so it pulses for one cycle.
- The first advance occurs TICK_M cycles after the `start` edge. Subsequent advances come every TICK_M cycles.
- Single sweep from IDLE: `done` is asserted W·TICK_M cycles after the `start` edge. `busy` falls in the same cycle as `done` rises.
- `step`: level-sensitive. Each cycle `step` is high in PAUSE gives one advance; upstream debounce/edge-detect supplies pulses.
- The shifter is combinational, so `y` is valid in the same cycle as the new `a`/`amt`/`lr`.

## Structure
- Package `shift_sweep_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE} sweep_state_t`.
  - Constants `LR_RIGHT`=1'b1 and `LR_LEFT`=1'b0.
- Sub-module `mod_m_counter` (parameter M=`TICK_M`) generates the tick:
  - Synchronous clear on `start` acceptance.
  - Enabled only in RUN.
- Single always_ff block for state/`a`/`amt`/`lr`/`done`; combinational next-state logic.

## Test plan
Benches use W=16, TICK_M=4.
1. Reset → `a`=0, `amt`=0, `lr`=1, `busy`=0. `load` of `din`=16'h2465, `dir_in`=0 → `a`=16'h2465, `lr`=0 next cycle; no tick activity.
2. `cont`=0, pulse `start` → `amt` steps 1..15 at cycles 4, 8, …, 60. At cycle 64: `amt`=0, `done`=1 for 1 cycle, `busy`=0.
3. `cont`=1, `auto_rev`=1, `lr`=1, run 2 sweeps → `lr` toggles to 0 at the first wrap (cycle 64) and back to 1 at cycle 128; `done` never asserts.
4. RUN at `amt`=5, `stop` → PAUSE with `amt`=5. 3× `step` → `amt`=8. `load` 16'h0001 → `a` updates. `start` → next advance 4 cycles later (`amt`=9).
5. `stop` asserted in the same cycle as a tick at `amt`=6 → PAUSE, `amt` stays 6. `start`+`stop` together in PAUSE → remains PAUSE.
6. Assert `reset` asynchronously mid-RUN at `amt`=11 → outputs go to reset values immediately, without waiting for a clock edge. Deassert, then `start` → first advance after 4 cycles, from 0.
